// File: rtl/bt_song_select_rx.sv
// Bluetooth UART receiver: oversampled 8N1 framing plus decode of the ASCII song commands '0'..'4'.
// Define BT_PARITY_CHECK_EN to receive 8E1 frames instead; a parity mismatch is then reported as a framing error.
module bt_song_select_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int OSR    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rxt,
  output logic [3:0] choose,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV = CLK_HZ / (BAUD * OSR);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OSR);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef BT_PARITY_CHECK_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          os_tick;
  logic [2:0]    state_q, state_d;
  logic [OW-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    settle_q, settle_d;
  logic [3:0]    choose_q, choose_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          frame_err_q, frame_err_d;
  logic          stop_good;
`ifdef BT_PARITY_CHECK_EN
  logic          parity_q, parity_d;
`endif

  assign os_tick = (tick_cnt_q == TW'(DIV - 1));

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    settle_d     = settle_q;
    choose_d     = choose_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    stop_good    = 1'b0;
`ifdef BT_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // The synchronizer needs two edges after reset before rx_s_q shows the real line;
        // a line already low at that point is a frame caught mid-flight and gets qualified as a break.
        if (settle_q != 2'd3) begin
          settle_d = settle_q + 2'd1;
          if (settle_q == 2'd2 && !rx_s_q) begin
            state_d  = S_BREAK;
            os_cnt_d = '0;
          end
        end else if (!rx_s_q) begin
          state_d  = S_START;
          os_cnt_d = '0;
        end
      end
      S_START: if (os_tick) begin
        if (os_cnt_q == OW'(OSR / 2 - 1)) begin
          os_cnt_d  = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      S_DATA: if (os_tick) begin
        if (os_cnt_q == OW'(OSR - 1)) begin
          os_cnt_d           = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef BT_PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
`ifdef BT_PARITY_CHECK_EN
      S_PARITY: if (os_tick) begin
        if (os_cnt_q == OW'(OSR - 1)) begin
          os_cnt_d = '0;
          parity_d = rx_s_q;
          state_d  = S_STOP;
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: if (os_tick) begin
        if (os_cnt_q == OW'(OSR - 1)) begin
          os_cnt_d = '0;
`ifdef BT_PARITY_CHECK_EN
          stop_good = rx_s_q && ((^shift_q) == parity_q);
`else
          stop_good = rx_s_q;
`endif
          if (stop_good) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            case (shift_q)
              8'h30:   choose_d = 4'b0000;
              8'h31:   choose_d = 4'b0001;
              8'h32:   choose_d = 4'b0010;
              8'h33:   choose_d = 4'b0100;
              8'h34:   choose_d = 4'b1000;
              default: choose_d = choose_q;
            endcase
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = rx_s_q ? S_IDLE : S_BREAK;
          end
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Any low cycle restarts the run of idle-high ticks.
        if (!rx_s_q) begin
          os_cnt_d = '0;
        end else if (os_tick) begin
          if (os_cnt_q == OW'(OSR - 1)) begin
            os_cnt_d = '0;
            state_d  = S_IDLE;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tick_cnt_d = os_tick ? '0 : tick_cnt_q + 1'b1;
    if (state_q == S_IDLE && state_d != S_IDLE) tick_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      state_q      <= S_IDLE;
      os_cnt_q     <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      settle_q     <= '0;
      choose_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
`ifdef BT_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rxt;
      rx_s_q       <= rx_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      settle_q     <= settle_d;
      choose_q     <= choose_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
`ifdef BT_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign choose     = choose_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_bt_song_select_rx.sv
// Bench for bt_song_select_rx: a transaction-level model predicts each frame's outcome and stop-bit time,
// and a per-cycle compare process holds the DUT to it. The clock/baud ratio is scaled to 64 cycles per bit.
module tb_bt_song_select_rx;

  localparam int TB_CLK_HZ = 1024000;
  localparam int TB_BAUD   = 16000;
  localparam int TB_OSR    = 16;
  localparam int BIT       = (TB_CLK_HZ / (TB_BAUD * TB_OSR)) * TB_OSR;
  localparam int WIN       = BIT / 4;
`ifdef BT_PARITY_CHECK_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         t_exp;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxt = 1'b1;
  logic [3:0] choose;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   nvalid   = 0;
  int   nferr    = 0;
  evt_t q[$];
  evt_t cur_e;
  logic [3:0] choose_m = 4'b0000;
  logic [7:0] data_m   = 8'h00;

  bt_song_select_rx #(.CLK_HZ(TB_CLK_HZ), .BAUD(TB_BAUD), .OSR(TB_OSR)) dut (
    .CLK(clk), .RST(rst), .rxt(rxt),
    .choose(choose), .byte_valid(byte_valid), .byte_data(byte_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] decode(input logic [3:0] cur, input logic [7:0] b);
    if (b >= 8'h31 && b <= 8'h34) return 4'(1 << (b - 8'h31));
    if (b == 8'h30) return 4'b0000;
    return cur;
  endfunction

  // Model: one expected event per frame, checked on the falling edge every cycle.
  always @(negedge clk) begin
    if (rst) begin
      choose_m = 4'b0000;
      data_m   = 8'h00;
      check(choose == 4'b0000 && !byte_valid && !frame_err && byte_data == 8'h00,
            "reset_outputs", {byte_valid, frame_err, 2'b00, choose, byte_data}, 0);
    end else begin
      if (byte_valid || frame_err) begin
        if (byte_valid) nvalid++;
        if (frame_err) nferr++;
        check(!(byte_valid && frame_err), "strobe_exclusive", {byte_valid, frame_err}, 0);
        check(q.size() != 0, "unexpected_strobe", {byte_valid, frame_err, byte_data}, 0);
        if (q.size() != 0) begin
          cur_e = q.pop_front();
          check(frame_err == cur_e.ferr, "strobe_kind", frame_err, cur_e.ferr);
          check(cyc >= cur_e.t_exp - WIN && cyc <= cur_e.t_exp + WIN, "strobe_time", cyc, cur_e.t_exp);
          if (!cur_e.ferr) begin
            data_m   = cur_e.data;
            choose_m = decode(choose_m, cur_e.data);
          end
        end
      end else if (q.size() != 0) begin
        check(cyc <= q[0].t_exp + WIN, "missed_strobe", cyc, q[0].t_exp);
        if (cyc > q[0].t_exp + WIN) void'(q.pop_front());
      end
      check(choose == choose_m, "choose", choose, choose_m);
      check(byte_data == data_m, "byte_data", byte_data, data_m);
    end
  end

  task automatic drive_bit(input logic v);
    rxt = v;
    repeat (BIT) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    rxt = 1'b1;
    repeat (n * BIT) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit expect_evt);
    evt_t e;
    if (expect_evt) begin
      e.ferr  = !(stop_ok && par_ok);
      e.data  = b;
      e.t_exp = cyc + (FRAME_BITS - 1) * BIT + BIT / 2;
      q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef BT_PARITY_CHECK_EN
    drive_bit((^b) ^ !par_ok);
`endif
    drive_bit(stop_ok);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv0, nf0, mode, gap;
    logic [7:0] b;

    repeat (4) @(posedge clk);
    #1 check(choose == 4'b0000, "rst_choose_literal", choose, 4'b0000);
    rst = 1'b0;
    idle_bits(2);

    // Single command byte.
    nv0 = nvalid;
    send_frame(8'h32, 1, 1, 1);
    idle_bits(1);
    #1;
    check(choose == 4'b0010, "t1_choose", choose, 4'b0010);
    check(byte_data == 8'h32, "t1_data", byte_data, 8'h32);
    check(nvalid - nv0 == 1, "t1_pulses", nvalid - nv0, 1);

    // Back-to-back with no idle gap.
    nv0 = nvalid;
    send_frame(8'h34, 1, 1, 1);
    #1 check(choose == 4'b1000, "t2_choose_first", choose, 4'b1000);
    send_frame(8'h30, 1, 1, 1);
    idle_bits(1);
    #1;
    check(choose == 4'b0000, "t2_choose_second", choose, 4'b0000);
    check(nvalid - nv0 == 2, "t2_pulses", nvalid - nv0, 2);

    // Non-command byte holds the selection.
    send_frame(8'h33, 1, 1, 1);
    send_frame(8'h41, 1, 1, 1);
    idle_bits(1);
    #1;
    check(choose == 4'b0100, "t3_choose_held", choose, 4'b0100);
    check(byte_data == 8'h41, "t3_data", byte_data, 8'h41);

    // Short low glitch is rejected at mid-start.
    nv0 = nvalid; nf0 = nferr;
    rxt = 1'b0;
    repeat (BIT * 3000 / 10416) @(posedge clk);
    idle_bits(2);
    #1 check(nvalid == nv0 && nferr == nf0, "t4_glitch_silent", nvalid - nv0 + nferr - nf0, 0);
    send_frame(8'h31, 1, 1, 1);
    idle_bits(1);
    #1 check(choose == 4'b0001, "t4_choose", choose, 4'b0001);

    // Bad stop bit followed by a long break.
    send_frame(8'h34, 1, 1, 1);
    idle_bits(1);
    nv0 = nvalid; nf0 = nferr;
    send_frame(8'h33, 0, 1, 1);
    repeat (4 * BIT) @(posedge clk);
    idle_bits(3);
    #1;
    check(nferr - nf0 == 1, "t5_ferr_pulses", nferr - nf0, 1);
    check(nvalid == nv0, "t5_no_byte", nvalid - nv0, 0);
    check(choose == 4'b1000, "t5_choose_held", choose, 4'b1000);
    send_frame(8'h31, 1, 1, 1);
    idle_bits(1);
    #1 check(choose == 4'b0001, "t5_recover", choose, 4'b0001);

    // Reset during data bit 4 aborts the frame.
    fork
      send_frame(8'h32, 1, 1, 0);
      begin
        repeat (BIT * 5 + BIT / 2) @(posedge clk);
        rst = 1'b1;
        #1 check(choose == 4'b0000, "t6_rst_choose", choose, 4'b0000);
        repeat (BIT * 5) @(posedge clk);
        rst = 1'b0;
      end
    join
    idle_bits(1);
    send_frame(8'h33, 1, 1, 1);
    idle_bits(1);
    #1 check(choose == 4'b0100, "t6_after_rst", choose, 4'b0100);

    // Reset released while the line is low: no frame may start until a full idle bit.
    nv0 = nvalid; nf0 = nferr;
    rxt = 1'b0;
    repeat (BIT) @(posedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    rst = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    idle_bits(3);
    #1 check(nvalid == nv0 && nferr == nf0, "t7_low_release_silent", nvalid - nv0 + nferr - nf0, 0);
    send_frame(8'h32, 1, 1, 1);
    idle_bits(1);
    #1 check(choose == 4'b0010, "t7_choose", choose, 4'b0010);

`ifdef BT_PARITY_CHECK_EN
    nf0 = nferr;
    send_frame(8'h31, 1, 0, 1);
    idle_bits(2);
    #1;
    check(nferr - nf0 == 1, "t8_parity_ferr", nferr - nf0, 1);
    check(choose == 4'b0010, "t8_choose_held", choose, 4'b0010);
`endif

    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      mode = $urandom_range(0, 9);
      gap  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) != 0) b = 8'h30 + 8'($urandom_range(0, 4));
      else b = 8'($urandom);
      if (mode == 0) begin
        rxt = 1'b0;
        repeat ($urandom_range(1, WIN)) @(posedge clk);
        idle_bits(2);
      end else if (mode == 1) begin
        send_frame(b, 0, 1, 1);
        repeat (gap * BIT) @(posedge clk);
        idle_bits(2);
      end else begin
        send_frame(b, 1, 1, 1);
        repeat (gap * BIT) @(posedge clk);
      end
    end

    idle_bits(3);
    #1 check(q.size() == 0, "pending_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
